disp_credit_issue: RTL and testbench

DISP_CREDIT_ISSUE -- requirements
Module: disp_credit_issue

---
 rtl/disp_credit_issue_pkg.sv | 16 +
 rtl/disp_credit_issue_if.sv | 32 +++
 rtl/disp_credit_issue_credit_counter.sv | 43 ++++
 rtl/disp_credit_issue.sv | 95 +++++++++
 tb/tb_disp_credit_issue.sv | 305 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/disp_credit_issue_pkg.sv
// Shared defaults and credit-width helper for the dispatch-to-issue credit path.
package disp_credit_issue_pkg;

    localparam int DEF_INPORT_NUM  = 4;
    localparam int DEF_OUTPORT_NUM = 4;
    localparam int DEF_IQ_SIZE     = 8;

    function automatic int credit_width(input int iq_size);
        return $clog2(iq_size + 1);
    endfunction

    localparam int DEF_CREDIT_W = credit_width(DEF_IQ_SIZE);

    typedef logic [DEF_CREDIT_W-1:0] credit_t;

endpackage

// File: rtl/disp_credit_issue_if.sv
// Dispatch-queue read side, issue-queue write side and credit return, grouped as one bundle.
interface disp_credit_issue_if #(
    parameter int  INPORT_NUM  = disp_credit_issue_pkg::DEF_INPORT_NUM,
    parameter int  OUTPORT_NUM = disp_credit_issue_pkg::DEF_OUTPORT_NUM,
    parameter int  IQ_SIZE     = disp_credit_issue_pkg::DEF_IQ_SIZE,
    parameter type dtype       = logic
);
    import disp_credit_issue_pkg::*;

    localparam int CW = credit_width(IQ_SIZE);

    logic                   i_flush;
    logic                   i_stall;
    logic [INPORT_NUM-1:0]  i_can_deq;
    dtype                   i_deq_data [INPORT_NUM];
    logic [INPORT_NUM-1:0]  o_deq_req;
    logic [CW-1:0]          i_credit_ret;
    logic [OUTPORT_NUM-1:0] o_iq_vld;
    dtype                   o_iq_data [OUTPORT_NUM];
    logic [CW-1:0]          o_credits;

    modport master (
        output i_flush, i_stall, i_can_deq, i_deq_data, i_credit_ret,
        input  o_deq_req, o_iq_vld, o_iq_data, o_credits
    );

    modport slave (
        input  i_flush, i_stall, i_can_deq, i_deq_data, i_credit_ret,
        output o_deq_req, o_iq_vld, o_iq_data, o_credits
    );

endinterface

// File: rtl/disp_credit_issue_credit_counter.sv
// Issue-queue credit counter: reload on reset/flush, otherwise subtract grant and add returns.
module credit_counter
    import disp_credit_issue_pkg::*;
#(
    parameter int IQ_SIZE = DEF_IQ_SIZE,
    parameter int CW      = credit_width(IQ_SIZE)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load_i,
    input  logic [CW-1:0] dec_i,
    input  logic [CW-1:0] ret_i,
    output logic [CW-1:0] credits_o
);

    logic [CW-1:0] credits_q;
    logic [CW-1:0] credits_d;
    logic [CW:0]   sum;
    logic          overflow;

    // One extra bit so an over-return is visible instead of wrapping.
    always_comb begin
        sum       = {1'b0, credits_q} - {1'b0, dec_i} + {1'b0, ret_i};
        overflow  = sum > (CW+1)'(IQ_SIZE);
        credits_d = sum[CW-1:0];
        if (load_i || overflow) begin
            credits_d = CW'(IQ_SIZE);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            credits_q <= CW'(IQ_SIZE);
        end else begin
            credits_q <= credits_d;
        end
    end

    a_credit_overflow: assert property (@(posedge clk) disable iff (!rst) !(!load_i && overflow));

    assign credits_o = credits_q;

endmodule

// File: rtl/disp_credit_issue.sv
// In-order dispatch of the leading valid slots into the issue queue, limited by IQ credits.
module disp_credit_issue
    import disp_credit_issue_pkg::*;
#(
    parameter int  INPORT_NUM  = DEF_INPORT_NUM,
    parameter int  OUTPORT_NUM = DEF_OUTPORT_NUM,
    parameter int  IQ_SIZE     = DEF_IQ_SIZE,
    parameter type dtype       = logic
) (
    input logic               clk,
    input logic               rst,
    disp_credit_issue_if.slave bus
);

    localparam int CW = credit_width(IQ_SIZE);

    logic [CW-1:0]          credits;
    int                     lead_cnt;
    int                     grant_cnt;
    logic                   run;
    logic [OUTPORT_NUM-1:0] iq_vld_d;
    dtype                   iq_data_d [OUTPORT_NUM];
    logic [OUTPORT_NUM-1:0] iq_vld_q;
    dtype                   iq_data_q [OUTPORT_NUM];

    // A hole in the valid vector ends the run so younger ops never pass older ones.
    always_comb begin
        lead_cnt = 0;
        run      = 1'b1;
        for (int k = 0; k < INPORT_NUM; k++) begin
            run = run & bus.i_can_deq[k];
            if (run) begin
                lead_cnt = lead_cnt + 1;
            end
        end
        grant_cnt = lead_cnt;
        if (int'(credits) < grant_cnt) begin
            grant_cnt = int'(credits);
        end
        if (OUTPORT_NUM < grant_cnt) begin
            grant_cnt = OUTPORT_NUM;
        end
        if (!rst || bus.i_flush || bus.i_stall) begin
            grant_cnt = 0;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < INPORT_NUM; gi++) begin : g_req
            assign bus.o_deq_req[gi] = (gi < grant_cnt);
        end

        for (gi = 0; gi < OUTPORT_NUM; gi++) begin : g_lane
            if (gi < INPORT_NUM) begin : g_src
                assign iq_vld_d[gi]  = (gi < grant_cnt);
                assign iq_data_d[gi] = iq_vld_d[gi] ? bus.i_deq_data[gi] : '0;
            end else begin : g_nosrc
                assign iq_vld_d[gi]  = 1'b0;
                assign iq_data_d[gi] = '0;
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst) begin
            iq_vld_q <= '0;
            for (int k = 0; k < OUTPORT_NUM; k++) begin
                iq_data_q[k] <= '0;
            end
        end else begin
            iq_vld_q <= iq_vld_d;
            for (int k = 0; k < OUTPORT_NUM; k++) begin
                iq_data_q[k] <= iq_data_d[k];
            end
        end
    end

    credit_counter #(
        .IQ_SIZE (IQ_SIZE),
        .CW      (CW)
    ) u_credit_counter (
        .clk       (clk),
        .rst       (rst),
        .load_i    (bus.i_flush),
        .dec_i     (CW'(grant_cnt)),
        .ret_i     (bus.i_credit_ret),
        .credits_o (credits)
    );

    assign bus.o_iq_vld  = iq_vld_q;
    assign bus.o_iq_data = iq_data_q;
    assign bus.o_credits = credits;

endmodule

// File: tb/tb_disp_credit_issue.sv
// Directed scenarios plus randomized traffic checked against a count-based credit model.
module tb_disp_credit_issue;

    localparam int IN  = 4;
    localparam int OUT = 4;
    localparam int IQ  = 8;
    localparam int CW  = $clog2(IQ + 1);

    typedef logic [7:0] data_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    disp_credit_issue_if #(.INPORT_NUM(IN), .OUTPORT_NUM(OUT), .IQ_SIZE(IQ), .dtype(data_t)) bus ();

    disp_credit_issue #(.INPORT_NUM(IN), .OUTPORT_NUM(OUT), .IQ_SIZE(IQ), .dtype(data_t)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference state: what the issue queue should see and how many slots remain.
    int             m_credits;
    logic [OUT-1:0] m_vld;
    data_t          m_data [OUT];

    function automatic int model_grant(input logic r, input logic fl, input logic st,
                                       input logic [IN-1:0] can, input int cr);
        int lead = 0;
        int n;
        if (!r || fl || st) return 0;
        while (lead < IN && can[lead]) lead++;
        n = lead;
        if (cr < n) n = cr;
        if (OUT < n) n = OUT;
        return n;
    endfunction

    function automatic logic [IN-1:0] low_mask(input int n);
        logic [IN-1:0] m = '0;
        for (int k = 0; k < n; k++) m[k] = 1'b1;
        return m;
    endfunction

    function automatic int cur_grant();
        return model_grant(rst, bus.i_flush, bus.i_stall, bus.i_can_deq, m_credits);
    endfunction

    task automatic drive(input logic r, input logic fl, input logic st,
                         input logic [IN-1:0] can, input int ret);
        @(negedge clk);
        rst              = r;
        bus.i_flush      = fl;
        bus.i_stall      = st;
        bus.i_can_deq    = can;
        bus.i_credit_ret = CW'(ret);
        for (int k = 0; k < IN; k++) bus.i_deq_data[k] = data_t'($urandom);
        #1;
    endtask

    task automatic advance();
        int n = cur_grant();
        if (!rst || bus.i_flush) begin
            m_credits = IQ;
            m_vld     = '0;
        end else begin
            for (int k = 0; k < OUT; k++) begin
                m_vld[k] = (k < n);
                if (k < n) m_data[k] = bus.i_deq_data[k];
            end
            m_credits = m_credits - n + int'(bus.i_credit_ret);
            if (m_credits > IQ) m_credits = IQ;
        end
        @(posedge clk);
        #1;
        $display("cycle: rst=%b flush=%b stall=%b can=%b ret=%0d -> vld=%b credits=%0d",
                 rst, bus.i_flush, bus.i_stall, bus.i_can_deq, bus.i_credit_ret,
                 bus.o_iq_vld, bus.o_credits);
    endtask

    task automatic test_reset();
        drive(1'b0, 1'b0, 1'b0, 4'b1111, 0);
        checks++;
        if (bus.o_deq_req !== 4'b0000) begin
            errors++; $display("FAIL reset_req: got %b want 0000", bus.o_deq_req);
        end
        advance();
        advance();
        checks++;
        if (bus.o_iq_vld !== 4'b0000) begin
            errors++; $display("FAIL reset_vld: got %b want 0000", bus.o_iq_vld);
        end
        checks++;
        if (bus.o_credits !== CW'(IQ)) begin
            errors++; $display("FAIL reset_credits: got %0d want %0d", bus.o_credits, IQ);
        end
        for (int k = 0; k < OUT; k++) begin
            checks++;
            if (bus.o_iq_data[k] !== 8'h00) begin
                errors++; $display("FAIL reset_data%0d: got %h want 00", k, bus.o_iq_data[k]);
            end
        end
    endtask

    task automatic test_full_burst();
        drive(1'b1, 1'b0, 1'b0, 4'b1111, 0);
        checks++;
        if (bus.o_deq_req !== 4'b1111) begin
            errors++; $display("FAIL burst_req: got %b want 1111", bus.o_deq_req);
        end
        advance();
        checks++;
        if (bus.o_iq_vld !== 4'b1111 || bus.o_credits !== CW'(4)) begin
            errors++; $display("FAIL burst_out: got vld=%b cr=%0d want vld=1111 cr=4",
                               bus.o_iq_vld, bus.o_credits);
        end
        for (int k = 0; k < OUT; k++) begin
            checks++;
            if (bus.o_iq_data[k] !== m_data[k]) begin
                errors++; $display("FAIL burst_data%0d: got %h want %h", k, bus.o_iq_data[k], m_data[k]);
            end
        end
    endtask

    task automatic test_hole();
        drive(1'b1, 1'b0, 1'b0, 4'b1011, 0);
        checks++;
        if (bus.o_deq_req !== 4'b0011) begin
            errors++; $display("FAIL hole_req: got %b want 0011", bus.o_deq_req);
        end
        advance();
        checks++;
        if (bus.o_iq_vld !== 4'b0011 || bus.o_credits !== CW'(2)) begin
            errors++; $display("FAIL hole_out: got vld=%b cr=%0d want vld=0011 cr=2",
                               bus.o_iq_vld, bus.o_credits);
        end
    endtask

    task automatic test_partial_credit();
        drive(1'b1, 1'b0, 1'b0, 4'b1111, 3);
        checks++;
        if (bus.o_deq_req !== 4'b0011) begin
            errors++; $display("FAIL partial_req: got %b want 0011", bus.o_deq_req);
        end
        advance();
        checks++;
        if (bus.o_credits !== CW'(3) || bus.o_iq_vld !== 4'b0011) begin
            errors++; $display("FAIL partial_out: got cr=%0d vld=%b want cr=3 vld=0011",
                               bus.o_credits, bus.o_iq_vld);
        end
    endtask

    task automatic test_zero_credit();
        drive(1'b1, 1'b0, 1'b0, 4'b0111, 0);
        advance();
        drive(1'b1, 1'b0, 1'b0, 4'b1111, 0);
        checks++;
        if (bus.o_deq_req !== 4'b0000 || bus.o_credits !== CW'(0)) begin
            errors++; $display("FAIL full_req: got req=%b cr=%0d want req=0000 cr=0",
                               bus.o_deq_req, bus.o_credits);
        end
        advance();
        checks++;
        if (bus.o_iq_vld !== 4'b0000) begin
            errors++; $display("FAIL full_vld: got %b want 0000", bus.o_iq_vld);
        end
        drive(1'b1, 1'b0, 1'b0, 4'b1111, 1);
        checks++;
        if (bus.o_deq_req !== 4'b0000) begin
            errors++; $display("FAIL ret_same_cycle_req: got %b want 0000", bus.o_deq_req);
        end
        advance();
        drive(1'b1, 1'b0, 1'b0, 4'b1111, 0);
        checks++;
        if (bus.o_deq_req !== 4'b0001) begin
            errors++; $display("FAIL ret_next_req: got %b want 0001", bus.o_deq_req);
        end
        advance();
        checks++;
        if (bus.o_iq_vld !== 4'b0001 || bus.o_credits !== CW'(0)) begin
            errors++; $display("FAIL ret_next_out: got vld=%b cr=%0d want vld=0001 cr=0",
                               bus.o_iq_vld, bus.o_credits);
        end
    endtask

    task automatic test_flush();
        drive(1'b1, 1'b1, 1'b0, 4'b1111, 0);
        advance();
        drive(1'b1, 1'b0, 1'b0, 4'b1111, 0);
        advance();
        drive(1'b1, 1'b0, 1'b0, 4'b0001, 0);
        advance();
        drive(1'b1, 1'b1, 1'b0, 4'b1111, 2);
        checks++;
        if (bus.o_deq_req !== 4'b0000 || bus.o_credits !== CW'(3)) begin
            errors++; $display("FAIL flush_req: got req=%b cr=%0d want req=0000 cr=3",
                               bus.o_deq_req, bus.o_credits);
        end
        advance();
        checks++;
        if (bus.o_iq_vld !== 4'b0000 || bus.o_credits !== CW'(8)) begin
            errors++; $display("FAIL flush_out: got vld=%b cr=%0d want vld=0000 cr=8",
                               bus.o_iq_vld, bus.o_credits);
        end
    endtask

    task automatic test_stall();
        drive(1'b1, 1'b0, 1'b0, 4'b1111, 0);
        advance();
        drive(1'b1, 1'b0, 1'b1, 4'b1111, 2);
        checks++;
        if (bus.o_deq_req !== 4'b0000) begin
            errors++; $display("FAIL stall_req: got %b want 0000", bus.o_deq_req);
        end
        advance();
        checks++;
        if (bus.o_iq_vld !== 4'b0000 || bus.o_credits !== CW'(6)) begin
            errors++; $display("FAIL stall_out: got vld=%b cr=%0d want vld=0000 cr=6",
                               bus.o_iq_vld, bus.o_credits);
        end
    endtask

    task automatic test_reset_mid();
        drive(1'b1, 1'b0, 1'b0, 4'b0111, 0);
        advance();
        checks++;
        if (bus.o_iq_vld !== 4'b0111) begin
            errors++; $display("FAIL mid_pre_vld: got %b want 0111", bus.o_iq_vld);
        end
        drive(1'b0, 1'b0, 1'b0, 4'b1111, 1);
        advance();
        checks++;
        if (bus.o_iq_vld !== 4'b0000 || bus.o_credits !== CW'(8)) begin
            errors++; $display("FAIL mid_rst_out: got vld=%b cr=%0d want vld=0000 cr=8",
                               bus.o_iq_vld, bus.o_credits);
        end
        drive(1'b1, 1'b0, 1'b0, 4'b1111, 0);
        checks++;
        if (bus.o_deq_req !== 4'b1111) begin
            errors++; $display("FAIL mid_post_req: got %b want 1111", bus.o_deq_req);
        end
        advance();
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            logic          r  = ($urandom_range(31, 0) != 0);
            logic          fl = ($urandom_range(15, 0) == 0);
            logic          st = ($urandom_range(7, 0) == 0);
            logic [IN-1:0] can = IN'($urandom);
            int            n  = model_grant(r, fl, st, can, m_credits);
            int            ret_max = (!r || fl) ? IQ : IQ - (m_credits - n);
            drive(r, fl, st, can, $urandom_range(ret_max, 0));
            checks++;
            if (bus.o_deq_req !== low_mask(cur_grant()) || bus.o_credits !== CW'(m_credits)) begin
                errors++; $display("FAIL rand_req[%0d]: got req=%b cr=%0d want req=%b cr=%0d", i,
                                   bus.o_deq_req, bus.o_credits, low_mask(cur_grant()), m_credits);
            end
            advance();
            checks++;
            if (bus.o_iq_vld !== m_vld) begin
                errors++; $display("FAIL rand_vld[%0d]: got %b want %b", i, bus.o_iq_vld, m_vld);
            end
            for (int k = 0; k < OUT; k++) begin
                if (m_vld[k]) begin
                    checks++;
                    if (bus.o_iq_data[k] !== m_data[k]) begin
                        errors++; $display("FAIL rand_data[%0d][%0d]: got %h want %h", i, k,
                                           bus.o_iq_data[k], m_data[k]);
                    end
                end
            end
        end
    endtask

    initial begin
        rst              = 1'b0;
        bus.i_flush      = 1'b0;
        bus.i_stall      = 1'b0;
        bus.i_can_deq    = '0;
        bus.i_credit_ret = '0;
        for (int k = 0; k < IN; k++) bus.i_deq_data[k] = '0;
        m_credits = IQ;
        m_vld     = '0;
        for (int k = 0; k < OUT; k++) m_data[k] = '0;

        test_reset();
        test_full_burst();
        test_hole();
        test_partial_credit();
        test_zero_credit();
        test_flush();
        test_stall();
        test_reset_mid();
        test_random();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
